branch_resolution_unit: RTL and testbench
=========================================

BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, branch history table depth (power of 2, >=2).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, cycles flush is held per redirect (>=1).
REQ-004 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_in  input  1  EX/MEM slot holds a valid instruction.
REQ-007 SHALL have ports branch, jal, jalr  input  1 each  instruction class (one-hot or all zero).
REQ-008 SHALL have port func_3_bits  input  3  branch condition code.
REQ-009 SHALL have ports rs1_val, rs2_val, pc, imm  input  XLEN each  operands, instruction PC, immediate.
REQ-010 SHALL have port predicted_taken  input  1  fetch-stage prediction for this instruction.
REQ-011 SHALL have port stall  input  1  pipeline hold, blocks acceptance.
REQ-012 SHALL have port bht_query_index  input  log2(BHT_ENTRIES)  fetch lookup index.
REQ-013 SHALL have port bht_predict  output  1  MSB of queried counter.
REQ-014 SHALL have ports pc_src  output  1 and target_pc  output  XLEN  redirect strobe and address.
REQ-015 SHALL have ports flush  output  1 and busy  output  1  pipeline flush, unit not accepting.
REQ-016 SHALL have port mispredict_count  output  16  saturating mispredict counter.

Function
REQ-017 Accept = valid_in & (branch|jal|jalr) & !stall & !busy, sampled at rising edge.
REQ-018 Taken per func_3_bits: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken; jal/jalr always taken.
REQ-019 Taken target: branch/jal pc+imm; jalr (rs1_val+imm) with bit0 cleared; all sums modulo 2^XLEN.
REQ-020 Mispredict = taken != predicted_taken; correct address = taken target if taken, else pc+4 (wraps).
REQ-021 FSM states IDLE, REDIRECT, FLUSH; IDLE->REDIRECT on accepted mispredict, else stay IDLE.
REQ-022 REDIRECT lasts exactly 1 cycle: pc_src=1, target_pc=correct address, flush=1, busy=1; then FLUSH if FLUSH_CYCLES>1, else IDLE.
REQ-023 FLUSH holds flush=1, busy=1, pc_src=0 for FLUSH_CYCLES-1 cycles, then IDLE; stall has no effect on REDIRECT/FLUSH timing.
REQ-024 Redirect latency: pc_src asserted the cycle immediately after the accepting edge; no redirect for correct predictions.
REQ-025 target_pc holds last redirect address when pc_src=0.
REQ-026 BHT: BHT_ENTRIES 2-bit saturating counters indexed by pc[log2(BHT_ENTRIES)+1:2]; updated only on accepted branch (not jal/jalr): +1 if taken, -1 if not, saturate 11/00.
REQ-027 bht_predict combinational from stored counters; same-cycle update to queried entry reads the old value.
REQ-028 mispredict_count increments on each accepted mispredict, saturates at 0xFFFF.

Reset
REQ-029 RESET_N low asynchronously forces IDLE, pc_src=0, flush=0, busy=0, target_pc=0, mispredict_count=0, all BHT counters=01.
REQ-030 Reset mid-REDIRECT/FLUSH aborts immediately; first accept possible on first edge after release.

Verification
REQ-031 BEQ rs1=rs2=5, pc=0x100, imm=0x20, predicted_taken=0 -> next cycle pc_src=1, target_pc=0x120, flush high 2 cycles, count=1.
REQ-032 BLTU rs1=0xFFFFFFFF, rs2=1, predicted_taken=1, pc=0x200 -> not taken, target_pc=0x204, counter at index 0 goes 01->00.
REQ-033 JALR rs1=0x1001, imm=0x4, predicted_taken=0 -> target_pc=0x1004 (bit0 cleared), BHT unchanged.
REQ-034 Back-to-back mispredicts: second valid_in while busy ignored; accepted only after busy drops; count increments once per accepted.
REQ-035 Four taken branches at same index, predicted correctly -> no pc_src, counter saturates at 11, bht_predict=1; func_3_bits=010 -> not taken.
REQ-036 RESET_N low during FLUSH -> flush/busy=0 immediately, BHT all 01, count=0.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// Branch resolution for the EX/MEM slot: evaluates branch/jump outcome, redirects fetch on a
// mispredict, holds a flush window, and trains a 2-bit branch history table.
module branch_resolution_unit #(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           valid_in,
    input  logic                           branch,
    input  logic                           jal,
    input  logic                           jalr,
    input  logic [2:0]                     func_3_bits,
    input  logic [XLEN-1:0]                rs1_val,
    input  logic [XLEN-1:0]                rs2_val,
    input  logic [XLEN-1:0]                pc,
    input  logic [XLEN-1:0]                imm,
    input  logic                           predicted_taken,
    input  logic                           stall,
    input  logic [$clog2(BHT_ENTRIES)-1:0] bht_query_index,
    output logic                           bht_predict,
    output logic                           pc_src,
    output logic [XLEN-1:0]                target_pc,
    output logic                           flush,
    output logic                           busy,
    output logic [15:0]                    mispredict_count
);

    localparam int          IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned N_ENT = BHT_ENTRIES;
    localparam int          CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       flush_cnt;
    logic [1:0]             bht [BHT_ENTRIES];

    logic                   accept;
    logic                   taken;
    logic                   mispredict;
    logic [XLEN-1:0]        taken_target;
    logic [XLEN-1:0]        correct_addr;
    logic [IDX_W-1:0]       upd_idx;

    assign accept     = valid_in & (branch | jal | jalr) & ~stall & ~busy;
    assign mispredict = taken ^ predicted_taken;
    assign upd_idx    = pc[IDX_W+1:2];

    always_comb begin
        taken = 1'b0;
        if (jal | jalr) begin
            taken = 1'b1;
        end else if (branch) begin
            case (func_3_bits)
                3'b000:  taken = (rs1_val == rs2_val);
                3'b001:  taken = (rs1_val != rs2_val);
                3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
                3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
                3'b110:  taken = (rs1_val <  rs2_val);
                3'b111:  taken = (rs1_val >= rs2_val);
                default: taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        taken_target = pc + imm;
        if (jalr) begin
            taken_target = (rs1_val + imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end
        correct_addr = taken ? taken_target : (pc + XLEN'(4));
    end

    // Counters are read combinationally; a same-cycle update lands after the edge.
    assign bht_predict = bht[bht_query_index][1];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < N_ENT; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && branch) begin
            if (taken && bht[upd_idx] != 2'b11) begin
                bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else if (!taken && bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state            <= IDLE;
            flush_cnt        <= '0;
            pc_src           <= 1'b0;
            flush            <= 1'b0;
            busy             <= 1'b0;
            target_pc        <= '0;
            mispredict_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pc_src <= 1'b0;
                    flush  <= 1'b0;
                    busy   <= 1'b0;
                    if (accept && mispredict) begin
                        state     <= REDIRECT;
                        pc_src    <= 1'b1;
                        flush     <= 1'b1;
                        busy      <= 1'b1;
                        target_pc <= correct_addr;
                        if (mispredict_count != '1) begin
                            mispredict_count <= mispredict_count + 16'd1;
                        end
                    end
                end
                REDIRECT: begin
                    pc_src <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state     <= FLUSH;
                        flush     <= 1'b1;
                        busy      <= 1'b1;
                        flush_cnt <= CNT_W'(FLUSH_CYCLES - 2);
                    end else begin
                        state <= IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                FLUSH: begin
                    pc_src <= 1'b0;
                    if (flush_cnt == '0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    pc_src <= 1'b0;
                    flush  <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: table-driven vectors through a scoreboard,
// plus hand sequences for back-to-back mispredicts, stall, BHT saturation and reset.
module tb_branch_resolution_unit;

    logic        CLK;
    logic        RESET_N;
    logic        valid_in;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  func_3_bits;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        predicted_taken;
    logic        stall;
    logic [3:0]  bht_query_index;
    logic        bht_predict;
    logic        pc_src;
    logic [31:0] target_pc;
    logic        flush;
    logic        busy;
    logic [15:0] mispredict_count;

    branch_resolution_unit #(
        .XLEN         (32),
        .BHT_ENTRIES  (16),
        .FLUSH_CYCLES (2)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .valid_in         (valid_in),
        .branch           (branch),
        .jal              (jal),
        .jalr             (jalr),
        .func_3_bits      (func_3_bits),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .pc               (pc),
        .imm              (imm),
        .predicted_taken  (predicted_taken),
        .stall            (stall),
        .bht_query_index  (bht_query_index),
        .bht_predict      (bht_predict),
        .pc_src           (pc_src),
        .target_pc        (target_pc),
        .flush            (flush),
        .busy             (busy),
        .mispredict_count (mispredict_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        exp_taken;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic        misp;
        logic [31:0] addr;
    } exp_t;

    vec_t        tbl [12];
    vec_t        v;
    exp_t        sb [$];
    logic [1:0]  bht_m [16];
    logic [15:0] exp_cnt;
    logic [31:0] last_target;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bht_train(input logic [3:0] idx, input logic tk);
        if (tk) begin
            if (bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'd1;
        end else begin
            if (bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'd1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        exp_cnt     = '0;
        last_target = '0;
    endtask

    task automatic drive(input vec_t d);
        branch          = d.br;
        jal             = d.jal;
        jalr            = d.jalr;
        func_3_bits     = d.f3;
        rs1_val         = d.rs1;
        rs2_val         = d.rs2;
        pc              = d.pc;
        imm             = d.imm;
        predicted_taken = d.pred;
        valid_in        = 1'b1;
    endtask

    // One instruction: drive, let it be accepted, then check redirect, flush window, count, BHT.
    task automatic apply(input vec_t d, input bit rel);
        exp_t       e;
        exp_t       got;
        int         fl;
        logic [3:0] idx;
        @(negedge CLK);
        if (rel) RESET_N = 1'b1;
        drive(d);
        e.misp = d.exp_taken ^ d.pred;
        e.addr = e.misp ? d.exp_addr : last_target;
        sb.push_back(e);
        if (e.misp) begin
            last_target = d.exp_addr;
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        idx = d.pc[5:2];
        if (d.br) bht_train(idx, d.exp_taken);
        @(negedge CLK);
        valid_in = 1'b0;
        got = sb.pop_front();
        check("pc_src", {31'd0, pc_src}, {31'd0, got.misp});
        check("target_pc", target_pc, got.addr);
        fl = 0;
        while (flush === 1'b1 && fl < 8) begin
            fl++;
            @(negedge CLK);
        end
        check("flush_len", fl, got.misp ? 32'd2 : 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("mispredict_count", {16'd0, mispredict_count}, {16'd0, exp_cnt});
        bht_query_index = idx;
        #1;
        check("bht_predict", {31'd0, bht_predict}, {31'd0, bht_m[idx][1]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // br jal jalr f3 rs1 rs2 pc imm pred exp_taken exp_addr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h200,      32'h40,       1'b1, 1'b0, 32'h204};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h5,        32'h5, 32'h100,      32'h20,       1'b0, 1'b1, 32'h120};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h1001,     32'h0, 32'h300,      32'h4,        1'b0, 1'b1, 32'h1004};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'b001, 32'h3,        32'h4, 32'h44,       32'h10,       1'b1, 1'b1, 32'h54};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h48,       32'hFFFFFFF0, 1'b0, 1'b1, 32'h38};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'b101, 32'hFFFFFFFF, 32'h1, 32'h4C,       32'h8,        1'b1, 1'b0, 32'h50};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h50,       32'h8,        1'b0, 1'b1, 32'h58};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h1,        32'h1, 32'h54,       32'h8,        1'b0, 1'b0, 32'h58};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h0,        32'h0, 32'hFFFFFFF0, 32'h20,       1'b0, 1'b1, 32'h10};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h1,        32'h2, 32'hFFFFFFFC, 32'h8,        1'b1, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'b110, 32'h1,        32'h2, 32'h60,       32'h100,      1'b1, 1'b1, 32'h160};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'b011, 32'h2,        32'h1, 32'h64,       32'h8,        1'b1, 1'b0, 32'h68};

        RESET_N = 1'b0;
        valid_in = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0; func_3_bits = '0;
        rs1_val = '0; rs2_val = '0; pc = '0; imm = '0; predicted_taken = 1'b0;
        stall = 1'b0; bht_query_index = '0;
        model_reset();

        #12;
        check("rst_pc_src", {31'd0, pc_src}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_target", target_pc, 32'd0);
        check("rst_count", {16'd0, mispredict_count}, 32'd0);
        check("rst_bht", {31'd0, bht_predict}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 12; i++) apply(tbl[i], 1'b0);

        // Repeated correctly predicted taken branches saturate the counter; 010 never takes.
        v = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h7, 32'h7, 32'h84, 32'h10, 1'b1, 1'b1, 32'h94};
        for (int i = 0; i < 4; i++) apply(v, 1'b0);
        check("bht_sat", {31'd0, bht_predict}, 32'd1);
        v = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h7, 32'h7, 32'h84, 32'h10, 1'b0, 1'b0, 32'h88};
        apply(v, 1'b0);

        // Stalled instruction is never accepted.
        v = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h500, 32'h4, 1'b0, 1'b1, 32'h504};
        @(negedge CLK);
        drive(v);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("stall_pc_src", {31'd0, pc_src}, 32'd0);
            check("stall_count", {16'd0, mispredict_count}, {16'd0, exp_cnt});
        end
        stall    = 1'b0;
        valid_in = 1'b0;

        // Mispredict held valid: accepted again only once busy has dropped.
        v = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h9, 32'h9, 32'h0C, 32'h30, 1'b0, 1'b1, 32'h3C};
        @(negedge CLK);
        drive(v);
        begin
            logic [3:0] ps;
            logic [3:0] bs;
            int         w;
            ps = 4'b1001;
            bs = 4'b1011;
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                check("b2b_pc_src", {31'd0, pc_src}, {31'd0, ps[k]});
                check("b2b_busy", {31'd0, busy}, {31'd0, bs[k]});
            end
            valid_in = 1'b0;
            w = 0;
            while (busy === 1'b1 && w < 8) begin
                w++;
                @(negedge CLK);
            end
            check("b2b_drain", {31'd0, busy}, 32'd0);
        end
        exp_cnt     = exp_cnt + 16'd2;
        last_target = 32'h3C;
        bht_train(4'd3, 1'b1);
        bht_train(4'd3, 1'b1);
        check("b2b_count", {16'd0, mispredict_count}, {16'd0, exp_cnt});
        check("b2b_target", target_pc, last_target);
        bht_query_index = 4'd3;
        #1;
        check("b2b_bht", {31'd0, bht_predict}, {31'd0, bht_m[3][1]});

        // Reset asserted mid-flush aborts at once and restores the BHT.
        v = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h700, 32'h10, 1'b0, 1'b1, 32'h710};
        @(negedge CLK);
        drive(v);
        @(negedge CLK);
        valid_in = 1'b0;
        check("pre_rst_pc_src", {31'd0, pc_src}, 32'd1);
        @(negedge CLK);
        check("pre_rst_flush", {31'd0, flush}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_flush", {31'd0, flush}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_pc_src", {31'd0, pc_src}, 32'd0);
        check("mid_rst_target", target_pc, 32'd0);
        check("mid_rst_count", {16'd0, mispredict_count}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            bht_query_index = 4'(i);
            #0.1;
            check("mid_rst_bht", {31'd0, bht_predict}, 32'd0);
        end
        model_reset();
        // Released on the driving negedge: the very next rising edge must accept.
        v = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h2, 32'h2, 32'h14, 32'h8, 1'b0, 1'b1, 32'h1C};
        apply(v, 1'b1);
        check("post_rst_bht", {31'd0, bht_predict}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
